sdram_arbit: RTL and testbench

- Central scheduler for the SDRAM controller. Owns the single SDRAM command/address/bank bus.
- Shares the bus between four sub-modules: init, auto-refresh, write-burst and read-burst.
- Grants one requester at a time by fixed priority, then muxes that requester's command, address and bank onto the SDRAM pins.
- Instantiated in the SDRAM top level. Replaces the inline state register and ref_en logic there.

---
 rtl/sdram_arbit.sv | 139 +++++++++++++
 tb/tb_sdram_arbit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: grants init/refresh/write/read ownership of the command bus and muxes the pins.
// Optional SDRAM_ARB_RR_EN: rotating write/read priority; refresh always wins.
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111,
    parameter int         ADDR_W  = 12,
    parameter int         BANK_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    output logic              ref_en,
    input  logic              flag_ref_end,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              flag_wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              flag_rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              ref_pending,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [4:0]        arb_state
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        ARBIT = 5'b00010,
        AREF  = 5'b00100,
        WRITE = 5'b01000,
        READ  = 5'b10000
    } state_t;

    state_t state, state_nxt;
    logic   ref_en_nxt, wr_en_nxt, rd_en_nxt;
    logic   wr_wins;

`ifdef SDRAM_ARB_RR_EN
    // last_grant: 1 = read was granted last, so write wins the next tie
    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (wr_en_nxt)
            last_grant <= 1'b0;
        else if (rd_en_nxt)
            last_grant <= 1'b1;
    end

    assign wr_wins = wr_req && (!rd_req || last_grant);
`else
    assign wr_wins = wr_req;
`endif

    always_comb begin
        state_nxt  = state;
        ref_en_nxt = 1'b0;
        wr_en_nxt  = 1'b0;
        rd_en_nxt  = 1'b0;
        case (state)
            IDLE: if (flag_init_end) state_nxt = ARBIT;
            ARBIT: begin
                if (ref_req) begin
                    state_nxt  = AREF;
                    ref_en_nxt = 1'b1;
                end else if (wr_wins) begin
                    state_nxt = WRITE;
                    wr_en_nxt = 1'b1;
                end else if (rd_req) begin
                    state_nxt = READ;
                    rd_en_nxt = 1'b1;
                end
            end
            AREF:  if (flag_ref_end) state_nxt = ARBIT;
            WRITE: if (flag_wr_end)  state_nxt = ARBIT;
            READ:  if (flag_rd_end)  state_nxt = ARBIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ref_en      <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            ref_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            ref_en      <= ref_en_nxt;
            wr_en       <= wr_en_nxt;
            rd_en       <= rd_en_nxt;
            ref_pending <= ((state == WRITE) || (state == READ)) && ref_req;
        end
    end

    // Pin mux follows the registered state only, so pins change with the grant edge
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (state)
            IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: ;
        endcase
    end

    assign arb_state = state;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: init, priority, pin mux, ref_pending, async reset, write/read tie policy.
module tb_sdram_arbit;
  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_ARBIT = 5'b00010;
  localparam logic [4:0] S_AREF  = 5'b00100;
  localparam logic [4:0] S_WRITE = 5'b01000;
  localparam logic [4:0] S_READ  = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_init_end = 1'b0;
  logic [3:0]  init_cmd = 4'b0010;
  logic [11:0] init_addr = 12'h400;
  logic        ref_req = 1'b0;
  logic        ref_en;
  logic        flag_ref_end = 1'b0;
  logic [3:0]  ref_cmd = 4'b0001;
  logic [11:0] ref_addr = 12'h123;
  logic        wr_req = 1'b0;
  logic        wr_en;
  logic        flag_wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [11:0] wr_addr = 12'h0A5;
  logic [1:0]  wr_bank = 2'b10;
  logic        rd_req = 1'b0;
  logic        rd_en;
  logic        flag_rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [11:0] rd_addr = 12'h35A;
  logic [1:0]  rd_bank = 2'b01;
  logic        ref_pending;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [4:0]  arb_state;

  int n_chk = 0;
  int n_fail = 0;

  sdram_arbit dut (
    .clk(clk), .rst_n(rst_n), .flag_init_end(flag_init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
    .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .ref_pending(ref_pending), .sdram_cmd(sdram_cmd),
    .sdram_addr(sdram_addr), .sdram_bank(sdram_bank), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_seq();
    flag_init_end = 1'b1;
    tick();
    flag_init_end = 1'b0;
  endtask

  logic [2:0] en_vec;
  assign en_vec = {ref_en, wr_en, rd_en};

  initial begin
    logic [4:0] exp_state;

    // Reset state
    tick(); tick();
    chk("rst_state", arb_state, S_IDLE);
    chk("rst_en", en_vec, 3'b000);
    chk("rst_pend", ref_pending, 1'b0);
    chk("idle_cmd", sdram_cmd, init_cmd);
    chk("idle_addr", sdram_addr, init_addr);
    chk("idle_bank", sdram_bank, 2'b00);
    rst_n = 1'b1;

    // Requests are ignored while init runs
    ref_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    chk("idle_hold", arb_state, S_IDLE);
    chk("idle_noen", en_vec, 3'b000);
    ref_req = 1'b0; wr_req = 1'b0;
    init_seq();
    chk("arbit_state", arb_state, S_ARBIT);
    chk("arbit_cmd", sdram_cmd, 4'b0111);
    chk("arbit_addr", sdram_addr, 12'h000);
    tick();
    chk("arbit_stay", arb_state, S_ARBIT);

    // All three requests together: refresh, then write, then read
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    chk("aref_state", arb_state, S_AREF);
    chk("aref_en", en_vec, 3'b100);
    chk("aref_cmd", sdram_cmd, ref_cmd);
    chk("aref_addr", sdram_addr, ref_addr);
    ref_req = 1'b0;
    tick();
    chk("aref_en_pulse", en_vec, 3'b000);
    flag_rd_end = 1'b1; flag_wr_end = 1'b1;
    tick();
    chk("aref_foreign_end", arb_state, S_AREF);
    flag_rd_end = 1'b0; flag_wr_end = 1'b0;
    flag_ref_end = 1'b1;
    tick();
    chk("aref_ret", arb_state, S_ARBIT);
    chk("aref_ret_en", en_vec, 3'b000);
    flag_ref_end = 1'b0;
    tick();
    chk("wr_state", arb_state, S_WRITE);
    chk("wr_en", en_vec, 3'b010);
    chk("wr_cmd", sdram_cmd, 4'b0100);
    chk("wr_addr", sdram_addr, 12'h0A5);
    chk("wr_bank", sdram_bank, 2'b10);
    wr_req = 1'b0;
    flag_wr_end = 1'b1;
    tick();
    chk("wr_ret", arb_state, S_ARBIT);
    flag_wr_end = 1'b0;
    tick();
    chk("rd_state", arb_state, S_READ);
    chk("rd_en", en_vec, 3'b001);
    chk("rd_cmd", sdram_cmd, rd_cmd);
    chk("rd_addr", sdram_addr, rd_addr);
    chk("rd_bank", sdram_bank, rd_bank);
    rd_req = 1'b0;
    tick();
    chk("rd_en_pulse", en_vec, 3'b000);
    flag_rd_end = 1'b1;
    tick();
    chk("rd_ret", arb_state, S_ARBIT);
    flag_rd_end = 1'b0;

    // Refresh arriving during a write raises ref_pending and wins the next grant
    wr_req = 1'b1;
    tick();
    chk("wr2_state", arb_state, S_WRITE);
    wr_req = 1'b0; ref_req = 1'b1;
    tick();
    chk("pend_set", ref_pending, 1'b1);
    chk("pend_hold_wr", arb_state, S_WRITE);
    flag_wr_end = 1'b1;
    tick();
    chk("pend_ret", arb_state, S_ARBIT);
    chk("pend_ret_en", en_vec, 3'b000);
    flag_wr_end = 1'b0;
    tick();
    chk("pend_aref", arb_state, S_AREF);
    chk("pend_aref_en", en_vec, 3'b100);
    chk("pend_clr", ref_pending, 1'b0);
    ref_req = 1'b0;
    flag_ref_end = 1'b1;
    tick();
    flag_ref_end = 1'b0;
    chk("aref2_ret", arb_state, S_ARBIT);

    // Asynchronous reset in the middle of a write
    wr_req = 1'b1;
    tick();
    chk("wr3_en", en_vec, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("arst_state", arb_state, S_IDLE);
    chk("arst_en", en_vec, 3'b000);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("arst_reinit", arb_state, S_IDLE);
    chk("arst_noen", en_vec, 3'b000);
    init_seq();
    chk("arst_arbit", arb_state, S_ARBIT);
    wr_req = 1'b0;

    // Write/read tie: 4-cycle bursts, end flag returned each time
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    init_seq();
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef SDRAM_ARB_RR_EN
      exp_state = (g % 2 == 0) ? S_WRITE : S_READ;
`else
      exp_state = S_WRITE;
`endif
      tick();
      chk("tie_grant", arb_state, exp_state);
      chk("tie_en", en_vec, (exp_state == S_WRITE) ? 3'b010 : 3'b001);
      tick(); tick(); tick();
      if (exp_state == S_WRITE) flag_wr_end = 1'b1;
      else                      flag_rd_end = 1'b1;
      tick();
      flag_wr_end = 1'b0; flag_rd_end = 1'b0;
      chk("tie_ret", arb_state, S_ARBIT);
    end
    wr_req = 1'b0; rd_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
